// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared constants and state encoding for the add_seq sequencer
package add_seq_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_NBYTES = 16;
  // Byte counter sized for the widest legal configuration.
  localparam int CNT_W      = $clog2(MAX_NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add8.sv
// rtl/add8.sv - 8-bit ripple-carry adder shared by the byte sequencer
module add8
  import add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[BYTE_W];

endmodule

// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-byte add sequencer over one add8; ADD_SEQ_SUB_EN adds the sub port
module add_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NBYTES-1:0]    a,
  input  logic [8*NBYTES-1:0]    b,
  input  logic                   ci_in,
`ifdef ADD_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [8*NBYTES-1:0]    s,
  output logic                   co,
  output logic                   ovf
);

  localparam int W = BYTE_W * NBYTES;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q;
  logic [W-1:0]       a_q, b_q, s_q;
  logic               carry_q, co_q, ovf_q;
  logic               load, step, last;
  logic [W-1:0]       b_eff;
  logic               c_init;
  logic [BYTE_W-1:0]  a_byte, b_byte, sum_byte;
  logic               sum_co;

  // B is inverted at accept time so the RUN datapath is identical for add and subtract.
`ifdef ADD_SEQ_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : ci_in;
`else
  assign b_eff  = b;
  assign c_init = ci_in;
`endif

  assign last   = (idx_q == CNT_W'(NBYTES - 1));
  assign a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
  assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];

  add8 u_add8 (
    .a  (a_byte),
    .b  (b_byte),
    .ci (carry_q),
    .s  (sum_byte),
    .co (sum_co)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      idx_q   <= '0;
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= c_init;
    end else if (step) begin
      s_q[idx_q*BYTE_W +: BYTE_W] <= sum_byte;
      carry_q <= sum_co;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        co_q  <= sum_co;
        ovf_q <= (a_q[W-1] == b_q[W-1]) && (sum_byte[BYTE_W-1] != a_q[W-1]);
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule
